dmem_scan: RTL
==============

# dmem_scan

Parametrised data memory with a single read/write port and a multi-cycle reduction engine. It succeeds the single-cycle max-compute data memory. Data width, address width and reduction mode are configurable. Reductions walk memory one word per clock under a start/busy/done handshake, and return both the extreme value and its address. It sits in the MEM stage, addressed by the ALU result, with write data from the rt operand path.

## Interface
Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 16, word-address width; depth = 2**ADDR_W
- CNT_W, ADDR_W+1, width of scan length (allows a full-memory scan)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- wr  input  1  write strobe
- rd  input  1  read strobe
- addr  input  ADDR_W  word address for rd/wr; base address for a scan
- din  input  DATA_W  write data
- dout  output  DATA_W  read data
- dout_valid  output  1  dout holds data from an accepted read
- scan_start  input  1  start a reduction (one-cycle pulse)
- scan_op  input  2  00 max unsigned, 01 min unsigned, 10 max signed, 11 min signed
- scan_len  input  CNT_W  number of words to scan
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse, result valid
- result  output  DATA_W  extreme value
- result_addr  output  ADDR_W  address of the extreme value

## Operation
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - scan_start with scan_len≥1 latches addr (ptr), scan_op and scan_len (remaining), then goes to SCAN.
  - scan_start with scan_len=0 goes to DONE with result=0 and result_addr=addr.
- SCAN:
  - Each cycle reads mem[ptr] and compares it against the accumulator.
  - The first word loads the accumulator unconditionally.
  - ptr increments modulo 2**ADDR_W, so wrap-around is legal.
  - remaining decrements; the cycle it reaches 0 moves the FSM to DONE.
- Ties: only a strictly better value replaces the accumulator, so result_addr is the lowest-visited address among equals.
- Signed modes compare two's-complement; unsigned modes compare raw.
- DONE: done=1 for one cycle, then the FSM returns to IDLE. result and result_addr hold until the next scan completes.
- Reads:
  - rd is accepted only when busy=0.
  - rd while busy is ignored: dout_valid=0 and dout is unchanged.
- Writes:
  - Writes are accepted in every state.
  - A write to the address being scanned in the same cycle: the scan sees the old data. A write to a not-yet-scanned address is seen by the scan.
  - Same-cycle rd and wr to the same address return the old data.
- scan_start while busy is ignored; there is no queueing.
- scan_start and rd in the same IDLE cycle: the scan is accepted, and the read is also serviced in that cycle.
- Reset:
  - Reset forces IDLE, busy=0, done=0, dout=0, dout_valid=0, result=0, result_addr=0, ptr=0, remaining=0.
  - Memory contents are not reset.
  - Reset mid-scan aborts the scan, with no done pulse.

## Timing
- Read: rd at edge N gives dout and dout_valid at N+1. No rd at N gives dout_valid=0 at N+1 and dout unchanged.
- Scan, scan_start at edge N with len C≥1:
  - busy=1 from N+1 through N+C.
  - Words are read at edges N+1…N+C.
  - done=1 and result valid at N+C+1; busy=0 in that cycle.
- Scan with len 0: done at N+1 and busy never asserts.
- Back-to-back scans: a new scan_start is accepted in the DONE cycle.
- busy, done, result, result_addr, dout and dout_valid are all registered, with no combinational input-to-output paths.

## Structure
- Package dmem_pkg holds:
  - scan_op_t enum: OP_MAXU, OP_MINU, OP_MAXS, OP_MINS
  - scan_state_t enum: IDLE, SCAN, DONE
  - the default DATA_W and ADDR_W constants, shared with the CPU top level
- Sub-module scan_cmp: combinational, parametrised by DATA_W. It takes a candidate, the accumulator and scan_op, and outputs "better" (strict comparison, signedness from op[1], min/max from op[0]).
- Memory is an inferred array in the top module; the FSM, ptr, remaining and accumulator registers are also in the top module.

## Test plan
- Write 5, 9, 3, 9 to addresses 0x10–0x13. MAXU with len=4 → done at N+5, result=9, result_addr=0x11.
- Write 0xFFFF_FFFF and 0x0000_0001 to 0x20–0x21. MAXU → result=0xFFFF_FFFF, addr=0x20. MAXS → result=1, addr=0x21. MINS → result=0xFFFF_FFFF.
- Write 7 to 0xFFFF and 2 to 0x0000. MINU with base 0xFFFF, len=2 → result=2, addr=0x0000 (wrap-around).
- len=0 at base 0x40 → done at N+1, busy never high, result=0, addr=0x40.
- During a 4-word scan:
  - rd is ignored (dout_valid=0).
  - A write of 0x100 to the last unscanned word is reflected: result=0x100.
  - A second scan_start is ignored.
- Start a 10-word scan and assert rst at cycle 3 → busy, done, result and dout are all 0 immediately. Memory is retained: a subsequent rd of 0x11 returns 9.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default widths for the scanning data memory.
//   scan_op_t    : reduction mode, bit 1 = signed compare, bit 0 = min (else max)
//   scan_state_t : reduction FSM states
//   DMEM_DATA_W / DMEM_ADDR_W : default word and word-address widths, also used
//                  by the CPU top level
package dmem_pkg;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_ADDR_W = 16;

   typedef enum logic [1:0] {
      OP_MAXU = 2'b00,
      OP_MINU = 2'b01,
      OP_MAXS = 2'b10,
      OP_MINS = 2'b11
   } scan_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

endpackage

// File: rtl/dmem_scan_if.sv
// dmem_scan_if: bus between the MEM stage and dmem_scan.
//   master : drives wr/rd/addr/din and the scan request (start/op/len)
//   slave  : the memory; returns dout/dout_valid and busy/done/result/result_addr
interface dmem_scan_if #(
   parameter int DATA_W = dmem_pkg::DMEM_DATA_W,
   parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
   parameter int CNT_W  = ADDR_W + 1
) ();

   logic                 wr;
   logic                 rd;
   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    din;
   logic [DATA_W-1:0]    dout;
   logic                 dout_valid;
   logic                 scan_start;
   dmem_pkg::scan_op_t   scan_op;
   logic [CNT_W-1:0]     scan_len;
   logic                 busy;
   logic                 done;
   logic [DATA_W-1:0]    result;
   logic [ADDR_W-1:0]    result_addr;

   modport master (
      output wr, rd, addr, din, scan_start, scan_op, scan_len,
      input  dout, dout_valid, busy, done, result, result_addr
   );

   modport slave (
      input  wr, rd, addr, din, scan_start, scan_op, scan_len,
      output dout, dout_valid, busy, done, result, result_addr
   );

endinterface

// File: rtl/dmem_scan_cmp.sv
// scan_cmp: combinational strict comparator for the reduction engine.
//   cand   : word just read from memory
//   acc    : current extreme value
//   op     : reduction mode (op[1] signed, op[0] min)
//   better : cand strictly beats acc; ties return 0 so the earliest address wins
module scan_cmp
   import dmem_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic [DATA_W-1:0] cand,
   input  logic [DATA_W-1:0] acc,
   input  scan_op_t          op,
   output logic              better
);

   logic gt;
   logic lt;

   assign gt     = op[1] ? ($signed(cand) > $signed(acc)) : (cand > acc);
   assign lt     = op[1] ? ($signed(cand) < $signed(acc)) : (cand < acc);
   assign better = op[0] ? lt : gt;

endmodule

// File: rtl/dmem_scan.sv
// dmem_scan: single-port data memory with a multi-cycle min/max reduction.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_scan_if.slave
//     wr/addr/din     write, accepted in every state
//     rd/addr         read, accepted when not busy; dout/dout_valid next cycle
//     scan_start/op/len/addr  start a reduction over len words from addr
//     busy/done/result/result_addr  reduction status and registered result
module dmem_scan
   import dmem_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int CNT_W  = ADDR_W + 1
) (
   input  logic        clk,
   input  logic        rst,
   dmem_scan_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   scan_state_t       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   scan_op_t          op_q, op_d;
   logic              first_q, first_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [ADDR_W-1:0] result_addr_q, result_addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;

   logic [DATA_W-1:0] cand;
   logic              better;

   // Read before this edge's write lands, so a same-cycle write to the word
   // under the pointer is not seen, while later words see earlier writes.
   assign cand = mem[ptr_q];

   scan_cmp #(.DATA_W(DATA_W)) u_cmp (
      .cand   (cand),
      .acc    (acc_q),
      .op     (op_q),
      .better (better)
   );

   always_ff @(posedge clk) begin
      if (bus.wr) mem[bus.addr] <= bus.din;
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      rem_d         = rem_q;
      op_d          = op_q;
      first_d       = first_q;
      acc_d         = acc_q;
      acc_addr_d    = acc_addr_q;
      result_d      = result_q;
      result_addr_d = result_addr_q;
      dout_d        = dout_q;
      dout_valid_d  = 1'b0;

      // Reads are serviced in IDLE and DONE, including alongside scan_start.
      if (bus.rd && state_q != SCAN) begin
         dout_d       = mem[bus.addr];
         dout_valid_d = 1'b1;
      end

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.scan_start) begin
               if (bus.scan_len == '0) begin
                  state_d       = DONE;
                  result_d      = '0;
                  result_addr_d = bus.addr;
               end else begin
                  state_d = SCAN;
                  ptr_d   = bus.addr;
                  rem_d   = bus.scan_len;
                  op_d    = bus.scan_op;
                  first_d = 1'b1;
               end
            end
         end
         SCAN: begin
            ptr_d   = ptr_q + ADDR_W'(1);
            rem_d   = rem_q - CNT_W'(1);
            first_d = 1'b0;
            if (first_q || better) begin
               acc_d      = cand;
               acc_addr_d = ptr_q;
            end
            if (rem_q == CNT_W'(1)) begin
               state_d       = DONE;
               result_d      = acc_d;
               result_addr_d = acc_addr_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         rem_q         <= '0;
         op_q          <= OP_MAXU;
         first_q       <= 1'b0;
         acc_q         <= '0;
         acc_addr_q    <= '0;
         result_q      <= '0;
         result_addr_q <= '0;
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         rem_q         <= rem_d;
         op_q          <= op_d;
         first_q       <= first_d;
         acc_q         <= acc_d;
         acc_addr_q    <= acc_addr_d;
         result_q      <= result_d;
         result_addr_q <= result_addr_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
      end
   end

   // Status outputs are decodes of the state register only.
   assign bus.busy        = (state_q == SCAN);
   assign bus.done        = (state_q == DONE);
   assign bus.result      = result_q;
   assign bus.result_addr = result_addr_q;
   assign bus.dout        = dout_q;
   assign bus.dout_valid  = dout_valid_q;

endmodule
